mask_encoder32to5: RTL and testbench



---
 rtl/mask_enc_pkg.sv | 13 +
 rtl/prio_enc32.sv | 29 ++
 rtl/mask_encoder32to5.sv | 85 ++++++++
 tb/tb_mask_encoder32to5.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mask_enc_pkg.sv
// rtl/mask_enc_pkg.sv - shared constants and state type for the 32-to-5 mask encoder
package mask_enc_pkg;

    localparam int N = 32;
    localparam int W = 5;

    // One-hot encoding so that any corrupted value is distinguishable and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b01,
        EMIT = 2'b10
    } state_e;

endpackage

// File: rtl/prio_enc32.sv
// rtl/prio_enc32.sv - combinational 32-bit priority encoder with any-set and single-bit flags
module prio_enc32
    import mask_enc_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         single
);

    always_comb begin
        idx = '0;
        // Scan toward the priority end so the last hit is the winning bit.
        if (LSB_FIRST) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) idx = W'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = W'(i);
            end
        end
        any    = |vec;
        single = any && ((vec & (vec - N'(1))) == '0);
    end

endmodule

// File: rtl/mask_encoder32to5.sv
// rtl/mask_encoder32to5.sv - accepts a multi-hot mask and emits one index per handshake in priority order
module mask_encoder32to5
    import mask_enc_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_mask,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         zero_pulse
);

    state_e       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         zero_pulse_q, zero_pulse_d;

    logic [W-1:0] enc_idx;
    logic         enc_any;
    logic         enc_single;

    prio_enc32 #(.LSB_FIRST(LSB_FIRST)) u_prio (
        .vec    (pending_q),
        .idx    (enc_idx),
        .any    (enc_any),
        .single (enc_single)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        zero_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_mask != '0) begin
                        pending_d = in_mask;
                        state_d   = EMIT;
                    end else begin
                        zero_pulse_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (!enc_any) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    pending_d = pending_q & ~(N'(1) << enc_idx);
                    if (enc_single) state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            zero_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            zero_pulse_q <= zero_pulse_d;
        end
    end

    // Outputs depend only on registered state, never directly on input ports.
    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == EMIT);
        out_idx    = out_valid ? enc_idx : '0;
        out_last   = out_valid && enc_single;
        zero_pulse = zero_pulse_q;
    end

endmodule

// File: tb/tb_mask_encoder32to5.sv
// tb/tb_mask_encoder32to5.sv - randomized self-checking bench for both priority orders of mask_encoder32to5
module tb_mask_encoder32to5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_mask;
    logic        out_ready;

    logic        in_ready_l, out_valid_l, out_last_l, zero_pulse_l;
    logic [4:0]  out_idx_l;
    logic        in_ready_m, out_valid_m, out_last_m, zero_pulse_m;
    logic [4:0]  out_idx_m;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mask_encoder32to5 #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_l),
        .in_mask    (in_mask),
        .out_valid  (out_valid_l),
        .out_ready  (out_ready),
        .out_idx    (out_idx_l),
        .out_last   (out_last_l),
        .zero_pulse (zero_pulse_l)
    );

    mask_encoder32to5 #(.LSB_FIRST(1'b0)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_m),
        .in_mask    (in_mask),
        .out_valid  (out_valid_m),
        .out_ready  (out_ready),
        .out_idx    (out_idx_m),
        .out_last   (out_last_m),
        .zero_pulse (zero_pulse_m)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready_l"},  32'(in_ready_l), 1);
        chk({tag, "_in_ready_m"},  32'(in_ready_m), 1);
        chk({tag, "_out_valid_l"}, 32'(out_valid_l), 0);
        chk({tag, "_out_valid_m"}, 32'(out_valid_m), 0);
        chk({tag, "_out_idx_l"},   32'(out_idx_l), 0);
        chk({tag, "_out_last_l"},  32'(out_last_l), 0);
    endtask

    // Offer one mask, then follow its beats against the set-bit list of the mask.
    task automatic send_mask(input logic [31:0] mask, input int stall, input bit rnd);
        int q[$];
        int j;
        int cyc;
        int k;
        bit exp_last;
        for (int b = 0; b < 32; b++) if (mask[b]) q.push_back(b);
        k = q.size();
        @(negedge clk);
        chk_idle("pre_accept");
        in_valid = 1'b1;
        in_mask  = mask;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (k == 0) begin
            @(negedge clk);
            chk("zero_pulse_l_hi", 32'(zero_pulse_l), 1);
            chk("zero_pulse_m_hi", 32'(zero_pulse_m), 1);
            chk_idle("zero_accept");
            @(negedge clk);
            chk("zero_pulse_l_lo", 32'(zero_pulse_l), 0);
            chk("zero_pulse_m_lo", 32'(zero_pulse_m), 0);
            chk_idle("zero_after");
        end else begin
            j   = 0;
            cyc = 0;
            while (j < k && cyc < 200) begin
                out_ready = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom % 2) : 1'b1);
                in_valid  = 1'($urandom % 2);
                in_mask   = $urandom;
                @(negedge clk);
                exp_last = (j == k - 1);
                chk("emit_out_valid_l", 32'(out_valid_l), 1);
                chk("emit_out_valid_m", 32'(out_valid_m), 1);
                chk("emit_in_ready_l",  32'(in_ready_l), 0);
                chk("emit_zero_pulse",  32'(zero_pulse_l), 0);
                chk("emit_idx_lsb",     32'(out_idx_l), 32'(q[j]));
                chk("emit_idx_msb",     32'(out_idx_m), 32'(q[k - 1 - j]));
                chk("emit_last_lsb",    32'(out_last_l), 32'(exp_last));
                chk("emit_last_msb",    32'(out_last_m), 32'(exp_last));
                @(posedge clk);
                #1;
                if (out_ready) j++;
                cyc++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            if (j < k) chk("beat_timeout", 32'(j), 32'(k));
            @(negedge clk);
            chk_idle("post_emit");
        end
    endtask

    initial begin
        int cyc;
        logic [31:0] m;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mask   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        chk("reset_zero_pulse", 32'(zero_pulse_l), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        send_mask(32'h0000_0001, 0, 1'b0);
        send_mask(32'h8000_0011, 0, 1'b0);
        send_mask(32'h0000_0000, 0, 1'b0);
        send_mask(32'h0000_F000, 3, 1'b0);
        send_mask(32'hFFFF_FFFF, 0, 1'b0);

        // Reset asserted mid-emit on the beat carrying index 10.
        @(negedge clk);
        in_valid = 1'b1;
        in_mask  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (out_idx_l != 5'd10 && cyc < 50);
        chk("reach_idx10", 32'(out_idx_l), 10);
        rst = 1'b1;
        #1;
        chk("rst_out_valid_l", 32'(out_valid_l), 0);
        chk("rst_out_valid_m", 32'(out_valid_m), 0);
        chk("rst_in_ready_l",  32'(in_ready_l), 1);
        chk("rst_in_ready_m",  32'(in_ready_m), 1);
        chk("rst_zero_pulse",  32'(zero_pulse_l), 0);
        @(posedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk_idle("after_rst");
        send_mask(32'h0000_0004, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            case ($urandom % 4)
                0:       m = $urandom & $urandom & $urandom;
                1:       m = $urandom;
                2:       m = 32'd1 << ($urandom % 32);
                default: m = ($urandom % 3 == 0) ? 32'd0 : ($urandom | $urandom);
            endcase
            send_mask(m, int'($urandom % 3), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
